// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one backing-memory port between the instruction-fetch path
//   (read-only) and the load/store path (read/write).  One requester is
//   granted at a time; the memory port is driven from registered copies of
//   the winner's address/data until the memory answers or the wait times out.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-low reset
//   i_req/i_addr      : instruction read request (held until i_done)
//   i_rdata/i_done    : instruction read data (held) and completion pulse
//   d_req/d_we/d_addr/d_wdata : data request, 1 = store / 0 = load
//   d_rdata/d_done    : load data (held) and completion pulse
//   m_req/m_we/m_addr/m_wdata : memory request side, stable through BUS
//   m_rdata/m_ready   : memory response, only honoured while m_req=1
//   busy/owner/err    : not-IDLE flag, 0 = instruction / 1 = data owner,
//                       timeout pulse coincident with done
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,

  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,

  output logic              busy,
  output logic              owner,
  output logic              err
);

  // Counter only needs to reach TIMEOUT_CYC-1: the edge that would make it
  // TIMEOUT_CYC is the one that aborts.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             lastOwner;
  logic [CNT_W-1:0] waitCnt;

  logic             grantData;
  logic             timeoutHit;

  // Tie goes to the side that did not win last time; a lone request wins.
  always_comb begin
    grantData = 1'b0;
    if (d_req && (!i_req || !lastOwner))
      grantData = 1'b1;
  end

  always_comb begin
    timeoutHit = 1'b0;
    if (TIMEOUT_CYC != 0)
      timeoutHit = (waitCnt == CNT_W'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lastOwner <= 1'b1;
      waitCnt   <= '0;
      i_rdata   <= '0;
      i_done    <= 1'b0;
      d_rdata   <= '0;
      d_done    <= 1'b0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      busy      <= 1'b0;
      owner     <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Completion and error are single-cycle pulses; they are only set on
      // the BUS->DONE edge and fall back here on the DONE->IDLE edge.
      i_done <= 1'b0;
      d_done <= 1'b0;
      err    <= 1'b0;

      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            state     <= BUS;
            busy      <= 1'b1;
            m_req     <= 1'b1;
            owner     <= grantData;
            lastOwner <= grantData;
            waitCnt   <= '0;
            if (grantData) begin
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
            end else begin
              m_we    <= 1'b0;
              m_addr  <= i_addr;
              m_wdata <= '0;
            end
          end
        end

        BUS: begin
          if (m_ready) begin
            state <= DONE;
            m_req <= 1'b0;
            if (!owner) begin
              i_rdata <= m_rdata;
              i_done  <= 1'b1;
            end else begin
              if (!m_we)
                d_rdata <= m_rdata;
              d_done <= 1'b1;
            end
          end else if (timeoutHit) begin
            state <= DONE;
            m_req <= 1'b0;
            err   <= 1'b1;
            if (!owner) begin
              i_rdata <= '0;
              i_done  <= 1'b1;
            end else begin
              if (!m_we)
                d_rdata <= '0;
              d_done <= 1'b1;
            end
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
        end

        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          waitCnt <= '0;
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          m_req   <= 1'b0;
          waitCnt <= '0;
        end
      endcase
    end
  end

endmodule
